add4_serial_seq: RTL and testbench
==================================

ADD4_SERIAL_SEQ -- requirements
Module: add4_serial_seq

Interface
REQ-001 SHALL have parameter NIBBLES, default 4, number of 4-bit slices per operation; operand width W = 4*NIBBLES.
REQ-002 SHALL have port clk_i, input, 1, single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_i, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port req_valid_i, input, 1, request operands valid.
REQ-005 SHALL have port req_ready_o, output, 1, block can accept a request.
REQ-006 SHALL have ports a_i and b_i, input, W each, addends; port c_in_i, input, 1, carry-in.
REQ-007 SHALL have ports fa_a_o and fa_b_o, output, 4 each, nibble operands driven to the external fulladd4 a/b inputs.
REQ-008 SHALL have port fa_c_in_o, output, 1, driven to fulladd4 c_in.
REQ-009 SHALL have ports fa_sum_i, input, 4, and fa_c_out_i, input, 1, taken from fulladd4 sum/c_out (combinational path).
REQ-010 SHALL have ports res_valid_o, output, 1; res_ready_i, input, 1; sum_o, output, W; c_out_o, output, 1.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, DONE.
REQ-012 SHALL assert req_ready_o only in IDLE.
REQ-013 SHALL register a_i, b_i, c_in_i and clear the slice index k on the accept edge (req_valid_i & req_ready_o), then move IDLE->RUN.
REQ-014 SHALL, in RUN, drive fa_a_o/fa_b_o with nibble k of the registered operands; fa_c_in_o = registered c_in when k=0, else the registered carry.
REQ-015 SHALL, at each RUN edge, write fa_sum_i into sum nibble k, load the carry register from fa_c_out_i, and increment k.
REQ-016 SHALL move RUN->DONE at the edge that captures k=NIBBLES-1, with c_out_o = final carry.
REQ-017 SHALL assert res_valid_o only in DONE, exactly NIBBLES cycles after the accept edge.
REQ-018 SHALL hold sum_o/c_out_o stable while res_valid_o=1 and res_ready_i=0.
REQ-019 SHALL move DONE->IDLE on res_valid_o & res_ready_i; a new request is accepted no earlier than the following cycle.
REQ-020 SHALL drive fa_a_o, fa_b_o and fa_c_in_o to 0 outside RUN.
REQ-021 SHALL ignore req_valid_i outside IDLE; operand changes during RUN/DONE do not affect the result.

Reset
REQ-022 SHALL, while reset_i=0, force state IDLE, k=0, and set req_ready_o=0, res_valid_o=0, sum_o=0, c_out_o=0 and fa_* outputs=0, independent of clk_i.
REQ-023 SHALL assert req_ready_o on the first clock edge after reset_i deasserts; a reset mid-RUN or mid-DONE discards the operation without emitting a result.

Configuration
REQ-024 SHALL, when ADD4_SEQ_OVF_EN is defined, add output ovf_o, 1 bit, signed overflow = (a[W-1]==b[W-1]) & (sum[W-1]!=a[W-1]), valid with res_valid_o, reset to 0.
REQ-025 SHALL, when ADD4_SEQ_OVF_EN is undefined, omit the ovf_o port and all its logic.

Structure
REQ-026 SHALL place the state enumeration and NIBBLE_W=4 in shared package add4_seq_pkg.
REQ-027 SHALL NOT instantiate fulladd4 internally; the adder is instantiated beside this block by the parent.
REQ-028 SHALL implement the FSM, index counter and result register in one module; no sub-module.

Verification (NIBBLES=4, behavioural fulladd4 attached)
REQ-029 SHALL cover a=0x00FF, b=0x0001, c_in=0 -> sum_o=0x0100, c_out_o=0, res_valid_o 4 cycles after accept.
REQ-030 SHALL cover a=0xFFFF, b=0x0000, c_in=1 -> sum_o=0x0000, c_out_o=1 (carry ripples across all slices).
REQ-031 SHALL cover res_ready_i held 0 for 3 cycles in DONE -> sum_o/c_out_o stable, req_ready_o=0, IDLE on the 4th cycle after ready rises.
REQ-032 SHALL cover reset_i pulsed low at k=2 -> all outputs 0 immediately, no result emitted; the next request 0x1234+0x1111 -> 0x2345.
REQ-033 SHALL cover, with ADD4_SEQ_OVF_EN defined, 0x7FFF+0x0001 -> sum_o=0x8000, ovf_o=1, c_out_o=0; and 0xFFFF+0x0001 -> ovf_o=0.
REQ-034 SHALL cover req_valid_i toggled with new operands during RUN -> the result reflects only the accepted operands.

Source files
------------

// File: rtl/add4_seq_pkg.sv
// rtl/add4_seq_pkg.sv - shared state encoding and slice width for the serial nibble adder sequencer
package add4_seq_pkg;

    // Width of one adder slice; the external fulladd4 works on this many bits.
    localparam int NIBBLE_W = 4;

    // Sequencer states: waiting for operands, stepping through slices, holding the result.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Width of a slice index able to address n slices (at least one bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/add4_serial_seq.sv
// rtl/add4_serial_seq.sv - serial W-bit adder driving an external fulladd4 one nibble per cycle (ovf_o with ADD4_SEQ_OVF_EN)
module add4_serial_seq
    import add4_seq_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic [NIBBLES*NIBBLE_W-1:0] a_i,
    input  logic [NIBBLES*NIBBLE_W-1:0] b_i,
    input  logic                       c_in_i,
    output logic [NIBBLE_W-1:0]        fa_a_o,
    output logic [NIBBLE_W-1:0]        fa_b_o,
    output logic                       fa_c_in_o,
    input  logic [NIBBLE_W-1:0]        fa_sum_i,
    input  logic                       fa_c_out_i,
    output logic                       res_valid_o,
    input  logic                       res_ready_i,
    output logic [NIBBLES*NIBBLE_W-1:0] sum_o,
`ifdef ADD4_SEQ_OVF_EN
    output logic                       ovf_o,
`endif
    output logic                       c_out_o
);

    localparam int W   = NIBBLES * NIBBLE_W;
    localparam int K_W = idx_width(NIBBLES);
    localparam logic [K_W-1:0] K_LAST = K_W'(NIBBLES - 1);

    state_t          state;
    logic [K_W-1:0]  k;
    logic            ready_q;
    logic            valid_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic            cin_q;
    logic            carry_q;
    logic [W-1:0]    sum_q;
    logic            cout_q;
`ifdef ADD4_SEQ_OVF_EN
    logic            ovf_q;
`endif

    logic [NIBBLE_W-1:0] fa_a;
    logic [NIBBLE_W-1:0] fa_b;
    logic                fa_c;

    // Sequencer: accept operands, step one slice per edge capturing the adder output, then hold the result.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state   <= ST_IDLE;
            k       <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef ADD4_SEQ_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    // Ready comes up one edge after reset or after the previous result drained.
                    ready_q <= 1'b1;
                    if (req_valid_i && ready_q) begin
                        a_q     <= a_i;
                        b_q     <= b_i;
                        cin_q   <= c_in_i;
                        k       <= '0;
                        ready_q <= 1'b0;
                        state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    for (int i = 0; i < NIBBLES; i++) begin
                        if (k == K_W'(i)) begin
                            sum_q[i*NIBBLE_W +: NIBBLE_W] <= fa_sum_i;
                        end
                    end
                    carry_q <= fa_c_out_i;
                    k       <= k + 1'b1;
                    if (k == K_LAST) begin
                        cout_q  <= fa_c_out_i;
`ifdef ADD4_SEQ_OVF_EN
                        // Top slice sum bit is the result sign; overflow when like-signed operands flip it.
                        ovf_q   <= (a_q[W-1] == b_q[W-1]) && (fa_sum_i[NIBBLE_W-1] != a_q[W-1]);
`endif
                        valid_q <= 1'b1;
                        state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Result registers are untouched here, so they stay stable until the handshake.
                    if (res_ready_i) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    ready_q <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Adder operand mux: current slice of the held operands during RUN, zero otherwise.
    always_comb begin
        fa_a = '0;
        fa_b = '0;
        fa_c = 1'b0;
        if (state == ST_RUN) begin
            fa_c = (k == '0) ? cin_q : carry_q;
            for (int i = 0; i < NIBBLES; i++) begin
                if (k == K_W'(i)) begin
                    fa_a = a_q[i*NIBBLE_W +: NIBBLE_W];
                    fa_b = b_q[i*NIBBLE_W +: NIBBLE_W];
                end
            end
        end
    end

    assign fa_a_o      = fa_a;
    assign fa_b_o      = fa_b;
    assign fa_c_in_o   = fa_c;
    assign req_ready_o = ready_q;
    assign res_valid_o = valid_q;
    assign sum_o       = sum_q;
    assign c_out_o     = cout_q;
`ifdef ADD4_SEQ_OVF_EN
    assign ovf_o       = ovf_q;
`endif

endmodule

// File: tb/tb_add4_serial_seq.sv
// tb/tb_add4_serial_seq.sv - self-checking bench for add4_serial_seq with a behavioural fulladd4 attached
module tb_add4_serial_seq;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic          clk;
    logic          reset_n;
    logic          req_valid;
    logic          req_ready;
    logic [W-1:0]  a_in;
    logic [W-1:0]  b_in;
    logic          c_in;
    logic [3:0]    fa_a;
    logic [3:0]    fa_b;
    logic          fa_cin;
    logic [3:0]    fa_sum;
    logic          fa_cout;
    logic          res_valid;
    logic          res_ready;
    logic [W-1:0]  sum;
    logic          c_out;
`ifdef ADD4_SEQ_OVF_EN
    logic          ovf;
`endif

    int errors = 0;
    int checks = 0;

    add4_serial_seq #(.NIBBLES(NIBBLES)) dut (
        .clk_i       (clk),
        .reset_i     (reset_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .a_i         (a_in),
        .b_i         (b_in),
        .c_in_i      (c_in),
        .fa_a_o      (fa_a),
        .fa_b_o      (fa_b),
        .fa_c_in_o   (fa_cin),
        .fa_sum_i    (fa_sum),
        .fa_c_out_i  (fa_cout),
        .res_valid_o (res_valid),
        .res_ready_i (res_ready),
        .sum_o       (sum),
`ifdef ADD4_SEQ_OVF_EN
        .ovf_o       (ovf),
`endif
        .c_out_o     (c_out)
    );

    // Behavioural fulladd4 beside the block.
    assign {fa_cout, fa_sum} = {1'b0, fa_a} + {1'b0, fa_b} + {4'b0, fa_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full operation; expectations come from plain integer arithmetic on the operands.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input int hold, input bit noise);
        longint unsigned full, lowmask, exp_carry, exp_fa;
        logic [W-1:0]    held_sum;
        logic            held_cout;
        int              cyc;
        full = longint'(a) + longint'(b) + longint'(cin);
        cyc = 0;
        while (!req_ready && cyc < 20) begin
            tick();
            cyc++;
        end
        check("req_ready_before_op", req_ready, 1);
        req_valid = 1'b1;
        a_in = a;
        b_in = b;
        c_in = cin;
        tick();
        if (!noise) req_valid = 1'b0;
        cyc = 0;
        while (!res_valid && cyc < 20) begin
            if (cyc < NIBBLES) begin
                lowmask   = (64'd1 << (4*cyc)) - 1;
                exp_carry = ((longint'(a) & lowmask) + (longint'(b) & lowmask) + longint'(cin)) >> (4*cyc);
                exp_fa    = ((((longint'(a) >> (4*cyc)) & 64'hF) << 5) |
                             (((longint'(b) >> (4*cyc)) & 64'hF) << 1) | (exp_carry & 64'h1));
                check("fa_slice", {55'd0, fa_a, fa_b, fa_cin}, exp_fa);
            end
            if (noise) begin
                req_valid = $urandom_range(0, 1);
                a_in = W'($urandom);
                b_in = W'($urandom);
                c_in = 1'($urandom);
            end
            tick();
            cyc++;
        end
        req_valid = 1'b0;
        check("latency", cyc, NIBBLES);
        check("sum", sum, full & ((64'd1 << W) - 1));
        check("c_out", c_out, (full >> W) & 64'h1);
        check("fa_zero_in_done", {fa_a, fa_b, fa_cin}, 0);
        check("req_ready_in_done", req_ready, 0);
`ifdef ADD4_SEQ_OVF_EN
        begin
            longint sa, sb, ss;
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            ss = sa + sb + longint'(cin);
            check("ovf", ovf, (ss > 32767 || ss < -32768) ? 1 : 0);
        end
`endif
        held_sum  = sum;
        held_cout = c_out;
        res_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_state", {res_valid, req_ready, c_out, sum},
                  {1'b1, 1'b0, held_cout, held_sum});
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("after_handshake", {res_valid, req_ready}, 2'b01);
    endtask

    initial begin
        int seen;
        reset_n   = 1'b0;
        req_valid = 1'b0;
        res_ready = 1'b0;
        a_in      = '0;
        b_in      = '0;
        c_in      = 1'b0;
        #1;
        check("reset_outputs", {req_ready, res_valid, c_out, sum, fa_a, fa_b, fa_cin}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("ready_low_before_edge", req_ready, 0);
        tick();
        check("ready_after_first_edge", req_ready, 1);

        do_op(16'h00FF, 16'h0001, 1'b0, 0, 1'b0);
        do_op(16'hFFFF, 16'h0000, 1'b1, 0, 1'b0);
        do_op(W'($urandom), W'($urandom), 1'($urandom), 3, 1'b0);
        do_op(16'hA5C3, 16'h5A3D, 1'b1, 1, 1'b1);

        // Reset pulse in the middle of RUN (slice index 2).
        req_valid = 1'b1;
        a_in = 16'hBEEF;
        b_in = 16'h1357;
        c_in = 1'b0;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_run_reset_outputs", {req_ready, res_valid, c_out, sum, fa_a, fa_b, fa_cin}, 0);
        tick();
        check("reset_held_outputs", {req_ready, res_valid, c_out, sum, fa_a, fa_b, fa_cin}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (res_valid) seen++;
            tick();
        end
        check("no_result_after_reset", seen, 0);
        do_op(16'h1234, 16'h1111, 1'b0, 0, 1'b0);
        check("sum_1234_1111", sum, 16'h2345);

        do_op(16'h7FFF, 16'h0001, 1'b0, 0, 1'b0);
        do_op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
        do_op(16'h8000, 16'h8000, 1'b0, 2, 1'b0);

        for (int n = 0; n < 10; n++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), $urandom_range(0, 3), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
